// File: rtl/fnd_scan_cntr.sv
// fnd_scan_cntr: 4-digit multiplexed 7-segment scanner with frame-latched values.
// Optional blink suppression is built only when FND_BLINK_EN is defined.
module fnd_scan_cntr #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] left_val,
    input  logic [7:0] right_val,
    input  logic       dp_on,
    input  logic [1:0] blink,
    output logic [7:0] seg_7,
    output logic [3:0] com
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic          started;
    logic [7:0]    cap_l;
    logic [7:0]    cap_r;
    logic          p_tc;
    logic          frame_start;
    logic          hide;

    assign p_tc        = (presc == P_LAST);
    assign frame_start = !started || (p_tc && idx == 2'd3);

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Prescaler and digit index; started marks the first post-reset clock.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc   <= '0;
            idx     <= 2'd0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (p_tc) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Latch both values once per frame so a frame never mixes old and new data.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cap_l <= 8'd0;
            cap_r <= 8'd0;
        end else if (frame_start) begin
            cap_l <= left_val;
            cap_r <= right_val;
        end
    end

`ifdef FND_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt;
    logic          phase;
    logic [1:0]    blink_q;

    // Blink phase timer; restarts visible when blinking is first requested.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            bcnt    <= '0;
            phase   <= 1'b0;
            blink_q <= 2'b00;
        end else begin
            blink_q <= blink;
            if (blink_q == 2'b00 && blink != 2'b00) begin
                bcnt  <= '0;
                phase <= 1'b0;
            end else if (bcnt == B_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    assign hide = phase && (idx[1] ? blink[1] : blink[0]);
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_blink;
    assign unused_blink = ^blink;
    assign hide = 1'b0;
`endif

    logic [7:0] val;
    logic [3:0] digit;
    logic [6:0] seg_nxt;
    logic       blank;

    // Select the pair and the BCD digit for the current index.
    always_comb begin
        val     = idx[1] ? cap_l : cap_r;
        digit   = idx[0] ? 4'(val / 8'd10) : 4'(val % 8'd10);
        seg_nxt = (val > 8'd99) ? 7'h3F : seg_code(digit);
        blank   = (presc == '0) || p_tc || hide;
    end

    // Registered drive; blanking edges of each period avoids ghosting.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            com   <= 4'hF;
            seg_7 <= 8'hFF;
        end else begin
            com   <= blank ? 4'hF : ~(4'b0001 << idx);
            seg_7 <= {~((idx == 2'd2) && dp_on), seg_nxt};
        end
    end

endmodule
